mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage.sv | 255 +++++++++++++++++++++++++
 tb/tb_mem_stage.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// ============================================================================
// Module      : mem_stage
// Description : Pipeline memory stage. Holds the EX->MEM register set (M),
//               issues aligned data-memory requests with byte lanes and
//               replicated store data, stalls the upstream stage while an
//               access waits for its acknowledge, and produces the registered
//               writeback bundle (W) with aligned, extended load data.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_stage #(
  parameter int DWIDTH   = 32,
  parameter int PC_WIDTH = 32
) (
  input  logic                clk,
  input  logic                rst,

  // EX stage handshake and instruction fields
  input  logic                ex_valid,
  output logic                ex_ready,
  input  logic [DWIDTH-1:0]   ex_alu_out,
  input  logic [DWIDTH-1:0]   ex_store_data,
  input  logic [PC_WIDTH-1:0] ex_pc_add4,
  input  logic                ex_mem_rd,
  input  logic                ex_mem_wr,
  input  logic [1:0]          ex_mem_size,
  input  logic                ex_load_unsign,
  input  logic [4:0]          ex_rd,
  input  logic                ex_reg_wen,
  input  logic [1:0]          ex_wb_sel,

  // Data memory port
  output logic                dmem_req,
  output logic                dmem_we,
  output logic [DWIDTH-1:0]   dmem_addr,
  output logic [DWIDTH-1:0]   dmem_wdata,
  output logic [3:0]          dmem_be,
  input  logic                dmem_ack,
  input  logic [DWIDTH-1:0]   dmem_rdata,

  // Forwarding path back to EX
  output logic [DWIDTH-1:0]   alu_out_forw,

  // Writeback bundle
  output logic                wb_valid,
  output logic [DWIDTH-1:0]   wb_alu_out,
  output logic [DWIDTH-1:0]   wb_load_data,
  output logic [PC_WIDTH-1:0] wb_pc_add4,
  output logic [4:0]          wb_rd,
  output logic                wb_reg_wen,
  output logic [1:0]          wb_wb_sel,
  output logic                misalign
);

  // Access size encodings; 2'b11 behaves as a word access.
  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  state_t state_q, state_d;

  // --------------------------------------------------------------------------
  // M register set
  // --------------------------------------------------------------------------
  logic                m_valid_q;
  logic [DWIDTH-1:0]   m_alu_out_q;
  logic [DWIDTH-1:0]   m_store_data_q;
  logic [PC_WIDTH-1:0] m_pc_add4_q;
  logic                m_mem_rd_q;
  logic                m_mem_wr_q;
  logic [1:0]          m_mem_size_q;
  logic                m_load_unsign_q;
  logic [4:0]          m_rd_q;
  logic                m_reg_wen_q;
  logic [1:0]          m_wb_sel_q;

  // --------------------------------------------------------------------------
  // W register set
  // --------------------------------------------------------------------------
  logic                wb_valid_q;
  logic [DWIDTH-1:0]   wb_alu_out_q;
  logic [DWIDTH-1:0]   wb_load_data_q;
  logic [PC_WIDTH-1:0] wb_pc_add4_q;
  logic [4:0]          wb_rd_q;
  logic                wb_reg_wen_q;
  logic [1:0]          wb_wb_sel_q;
  logic                misalign_q;

  // --------------------------------------------------------------------------
  // Combinational access decode
  // --------------------------------------------------------------------------
  logic              mem_op;
  logic              m_misalign;
  logic              m_mem;
  logic              stall;
  logic [3:0]        be_raw;
  logic [DWIDTH-1:0] wdata_raw;
  logic [DWIDTH-1:0] load_shifted;
  logic [DWIDTH-1:0] load_data_d;

  // Misalignment only matters for an actual valid load/store; a stray odd ALU
  // result on an arithmetic instruction must not suppress its writeback.
  assign mem_op     = m_valid_q & (m_mem_rd_q | m_mem_wr_q);
  assign m_misalign = mem_op &
                      (((m_mem_size_q == SIZE_HALF) & m_alu_out_q[0]) |
                       (m_mem_size_q[1] & (m_alu_out_q[1:0] != 2'b00)));
  assign m_mem      = mem_op & ~m_misalign;

  // An ack with no request outstanding cannot reach stall since m_mem gates it.
  assign stall      = m_mem & ~dmem_ack;
  assign ex_ready   = ~stall;

  assign dmem_req     = m_mem;
  assign dmem_we      = m_mem_wr_q;
  assign dmem_addr    = {m_alu_out_q[DWIDTH-1:2], 2'b00};
  assign dmem_wdata   = wdata_raw;
  // Lanes are quiet unless a request is actually presented.
  assign dmem_be      = m_mem ? be_raw : 4'b0000;
  assign alu_out_forw = m_alu_out_q;

  // Byte-lane enables and lane-replicated store data for the access size.
  always_comb begin
    be_raw    = 4'b1111;
    wdata_raw = m_store_data_q;
    case (m_mem_size_q)
      SIZE_BYTE: begin
        be_raw    = 4'b0001 << m_alu_out_q[1:0];
        wdata_raw = {(DWIDTH/8){m_store_data_q[7:0]}};
      end
      SIZE_HALF: begin
        be_raw    = 4'b0011 << {m_alu_out_q[1], 1'b0};
        wdata_raw = {(DWIDTH/16){m_store_data_q[15:0]}};
      end
      default: begin
        be_raw    = 4'b1111;
        wdata_raw = m_store_data_q;
      end
    endcase
  end

  // Align the returned word to bit 0 and extend to full width for loads.
  always_comb begin
    load_shifted = dmem_rdata >> {m_alu_out_q[1:0], 3'b000};
    load_data_d  = '0;
    if (m_mem & m_mem_rd_q) begin
      case (m_mem_size_q)
        SIZE_BYTE: load_data_d = {{(DWIDTH-8){~m_load_unsign_q & load_shifted[7]}},
                                  load_shifted[7:0]};
        SIZE_HALF: load_data_d = {{(DWIDTH-16){~m_load_unsign_q & load_shifted[15]}},
                                  load_shifted[15:0]};
        default:   load_data_d = load_shifted;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Wait-state FSM
  // --------------------------------------------------------------------------

  // Next-state: enter WAIT while an access is unacknowledged, leave on ack.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:  if (stall)  state_d = ST_WAIT;
      ST_WAIT: if (!stall) state_d = ST_RUN;
      default: state_d = ST_RUN;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // Register sets
  // --------------------------------------------------------------------------

  // M captures the EX instruction whenever the stage is not stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid_q       <= 1'b0;
      m_alu_out_q     <= '0;
      m_store_data_q  <= '0;
      m_pc_add4_q     <= '0;
      m_mem_rd_q      <= 1'b0;
      m_mem_wr_q      <= 1'b0;
      m_mem_size_q    <= 2'b00;
      m_load_unsign_q <= 1'b0;
      m_rd_q          <= 5'd0;
      m_reg_wen_q     <= 1'b0;
      m_wb_sel_q      <= 2'b00;
    end else if (ex_ready) begin
      m_valid_q       <= ex_valid;
      m_alu_out_q     <= ex_alu_out;
      m_store_data_q  <= ex_store_data;
      m_pc_add4_q     <= ex_pc_add4;
      m_mem_rd_q      <= ex_mem_rd;
      m_mem_wr_q      <= ex_mem_wr;
      m_mem_size_q    <= ex_mem_size;
      m_load_unsign_q <= ex_load_unsign;
      m_rd_q          <= ex_rd;
      m_reg_wen_q     <= ex_reg_wen;
      m_wb_sel_q      <= ex_wb_sel;
    end
  end

  // W takes M on free-running edges; a stall holds contents but emits a bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_valid_q     <= 1'b0;
      wb_alu_out_q   <= '0;
      wb_load_data_q <= '0;
      wb_pc_add4_q   <= '0;
      wb_rd_q        <= 5'd0;
      wb_reg_wen_q   <= 1'b0;
      wb_wb_sel_q    <= 2'b00;
      misalign_q     <= 1'b0;
    end else if (stall) begin
      wb_valid_q     <= 1'b0;
      misalign_q     <= 1'b0;
    end else begin
      wb_valid_q     <= m_valid_q;
      wb_alu_out_q   <= m_alu_out_q;
      wb_load_data_q <= load_data_d;
      wb_pc_add4_q   <= m_pc_add4_q;
      wb_rd_q        <= m_rd_q;
      // A misaligned access retires as a no-op so software sees the flag only.
      wb_reg_wen_q   <= m_reg_wen_q & ~m_misalign;
      wb_wb_sel_q    <= m_wb_sel_q;
      misalign_q     <= m_misalign;
    end
  end

  assign wb_valid     = wb_valid_q;
  assign wb_alu_out   = wb_alu_out_q;
  assign wb_load_data = wb_load_data_q;
  assign wb_pc_add4   = wb_pc_add4_q;
  assign wb_rd        = wb_rd_q;
  assign wb_reg_wen   = wb_reg_wen_q;
  assign wb_wb_sel    = wb_wb_sel_q;
  assign misalign     = misalign_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_stage.sv
// ============================================================================
// Module      : tb_mem_stage
// Description : Directed self-checking bench for mem_stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_stage;

  logic        clk;
  logic        rst;
  logic        ex_valid;
  logic        ex_ready;
  logic [31:0] ex_alu_out;
  logic [31:0] ex_store_data;
  logic [31:0] ex_pc_add4;
  logic        ex_mem_rd;
  logic        ex_mem_wr;
  logic [1:0]  ex_mem_size;
  logic        ex_load_unsign;
  logic [4:0]  ex_rd;
  logic        ex_reg_wen;
  logic [1:0]  ex_wb_sel;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic [31:0] alu_out_forw;
  logic        wb_valid;
  logic [31:0] wb_alu_out;
  logic [31:0] wb_load_data;
  logic [31:0] wb_pc_add4;
  logic [4:0]  wb_rd;
  logic        wb_reg_wen;
  logic [1:0]  wb_wb_sel;
  logic        misalign;

  int checks = 0;
  int errors = 0;

  mem_stage #(.DWIDTH(32), .PC_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_alu_out(ex_alu_out),
    .ex_store_data(ex_store_data), .ex_pc_add4(ex_pc_add4),
    .ex_mem_rd(ex_mem_rd), .ex_mem_wr(ex_mem_wr), .ex_mem_size(ex_mem_size),
    .ex_load_unsign(ex_load_unsign), .ex_rd(ex_rd), .ex_reg_wen(ex_reg_wen),
    .ex_wb_sel(ex_wb_sel),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_ack(dmem_ack),
    .dmem_rdata(dmem_rdata),
    .alu_out_forw(alu_out_forw),
    .wb_valid(wb_valid), .wb_alu_out(wb_alu_out), .wb_load_data(wb_load_data),
    .wb_pc_add4(wb_pc_add4), .wb_rd(wb_rd), .wb_reg_wen(wb_reg_wen),
    .wb_wb_sel(wb_wb_sel), .misalign(misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one EX instruction (stimulus only).
  task automatic drive_ex(input logic v, input logic [31:0] alu, input logic [31:0] st,
                          input logic [31:0] pc, input logic rd_op, input logic wr_op,
                          input logic [1:0] size, input logic uns, input logic [4:0] rd,
                          input logic wen, input logic [1:0] sel);
    ex_valid = v; ex_alu_out = alu; ex_store_data = st; ex_pc_add4 = pc;
    ex_mem_rd = rd_op; ex_mem_wr = wr_op; ex_mem_size = size; ex_load_unsign = uns;
    ex_rd = rd; ex_reg_wen = wen; ex_wb_sel = sel;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (ex_ready !== 1'b1) begin errors++; $display("FAIL reset_ex_ready: got %b want 1", ex_ready); end
    checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL reset_dmem_req: got %b want 0", dmem_req); end
    checks++; if (dmem_be !== 4'b0000) begin errors++; $display("FAIL reset_dmem_be: got %b want 0000", dmem_be); end
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL reset_wb_valid: got %b want 0", wb_valid); end
    checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL reset_misalign: got %b want 0", misalign); end
    checks++; if (alu_out_forw !== 32'h0) begin errors++; $display("FAIL reset_alu_out_forw: got %h want 0", alu_out_forw); end
    checks++; if (wb_load_data !== 32'h0) begin errors++; $display("FAIL reset_wb_load_data: got %h want 0", wb_load_data); end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_alu_pass();
    @(negedge clk);
    drive_ex(1'b1, 32'h1234, 32'h0, 32'h88, 1'b0, 1'b0, 2'b10, 1'b0, 5'd5, 1'b1, 2'b01);
    @(negedge clk);
    ex_valid = 1'b0;
    checks++; if (alu_out_forw !== 32'h1234) begin errors++; $display("FAIL alu_forw: got %h want 00001234", alu_out_forw); end
    checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL alu_no_req: got %b want 0", dmem_req); end
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL alu_wb_early: got %b want 0", wb_valid); end
    @(negedge clk);
    checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL alu_wb_valid: got %b want 1", wb_valid); end
    checks++; if (wb_alu_out !== 32'h1234) begin errors++; $display("FAIL alu_wb_alu_out: got %h want 00001234", wb_alu_out); end
    checks++; if (wb_rd !== 5'd5) begin errors++; $display("FAIL alu_wb_rd: got %0d want 5", wb_rd); end
    checks++; if (wb_reg_wen !== 1'b1) begin errors++; $display("FAIL alu_wb_reg_wen: got %b want 1", wb_reg_wen); end
    checks++; if (wb_pc_add4 !== 32'h88) begin errors++; $display("FAIL alu_wb_pc_add4: got %h want 00000088", wb_pc_add4); end
    checks++; if (wb_wb_sel !== 2'b01) begin errors++; $display("FAIL alu_wb_sel: got %b want 01", wb_wb_sel); end
    checks++; if (wb_load_data !== 32'h0) begin errors++; $display("FAIL alu_wb_load_data: got %h want 0", wb_load_data); end
    @(negedge clk);
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL alu_wb_single: got %b want 0", wb_valid); end
  endtask

  // Load at 'addr' acknowledged in its first cycle.
  task automatic test_load(input string name, input logic [31:0] addr, input logic [1:0] size,
                           input logic uns, input logic [31:0] rdata,
                           input logic [31:0] exp_addr, input logic [3:0] exp_be,
                           input logic [31:0] exp_data);
    @(negedge clk);
    drive_ex(1'b1, addr, 32'h0, 32'h200, 1'b1, 1'b0, size, uns, 5'd6, 1'b1, 2'b10);
    @(negedge clk);
    ex_valid = 1'b0;
    checks++; if (dmem_req !== 1'b1) begin errors++; $display("FAIL %s_req: got %b want 1", name, dmem_req); end
    checks++; if (dmem_we !== 1'b0) begin errors++; $display("FAIL %s_we: got %b want 0", name, dmem_we); end
    checks++; if (dmem_addr !== exp_addr) begin errors++; $display("FAIL %s_addr: got %h want %h", name, dmem_addr, exp_addr); end
    checks++; if (dmem_be !== exp_be) begin errors++; $display("FAIL %s_be: got %b want %b", name, dmem_be, exp_be); end
    dmem_ack = 1'b1; dmem_rdata = rdata;
    #1;
    checks++; if (ex_ready !== 1'b1) begin errors++; $display("FAIL %s_ready_on_ack: got %b want 1", name, ex_ready); end
    @(negedge clk);
    dmem_ack = 1'b0; dmem_rdata = 32'h0;
    checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL %s_wb_valid: got %b want 1", name, wb_valid); end
    checks++; if (wb_load_data !== exp_data) begin errors++; $display("FAIL %s_data: got %h want %h", name, wb_load_data, exp_data); end
    checks++; if (wb_rd !== 5'd6) begin errors++; $display("FAIL %s_wb_rd: got %0d want 6", name, wb_rd); end
  endtask

  task automatic test_store(input string name, input logic [31:0] addr, input logic [1:0] size,
                            input logic [31:0] st, input logic [3:0] exp_be,
                            input logic [31:0] exp_wdata);
    @(negedge clk);
    drive_ex(1'b1, addr, st, 32'h300, 1'b0, 1'b1, size, 1'b0, 5'd0, 1'b0, 2'b00);
    @(negedge clk);
    ex_valid = 1'b0;
    checks++; if (dmem_req !== 1'b1) begin errors++; $display("FAIL %s_req: got %b want 1", name, dmem_req); end
    checks++; if (dmem_we !== 1'b1) begin errors++; $display("FAIL %s_we: got %b want 1", name, dmem_we); end
    checks++; if (dmem_be !== exp_be) begin errors++; $display("FAIL %s_be: got %b want %b", name, dmem_be, exp_be); end
    checks++; if (dmem_wdata !== exp_wdata) begin errors++; $display("FAIL %s_wdata: got %h want %h", name, dmem_wdata, exp_wdata); end
    dmem_ack = 1'b1;
    @(negedge clk);
    dmem_ack = 1'b0;
    checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL %s_wb_valid: got %b want 1", name, wb_valid); end
    checks++; if (wb_load_data !== 32'h0) begin errors++; $display("FAIL %s_load_data: got %h want 0", name, wb_load_data); end
  endtask

  task automatic test_wait_states();
    @(negedge clk);
    drive_ex(1'b1, 32'h200, 32'h0, 32'h300, 1'b1, 1'b0, 2'b10, 1'b0, 5'd7, 1'b1, 2'b10);
    @(negedge clk);
    // Next instruction waits at the EX boundary until the ack edge.
    drive_ex(1'b1, 32'h55, 32'h0, 32'h304, 1'b0, 1'b0, 2'b00, 1'b0, 5'd9, 1'b1, 2'b00);
    for (int i = 0; i < 3; i++) begin
      checks++; if (ex_ready !== 1'b0) begin errors++; $display("FAIL wait_ready_c%0d: got %b want 0", i, ex_ready); end
      checks++; if (dmem_req !== 1'b1) begin errors++; $display("FAIL wait_req_c%0d: got %b want 1", i, dmem_req); end
      checks++; if (dmem_addr !== 32'h200) begin errors++; $display("FAIL wait_addr_c%0d: got %h want 00000200", i, dmem_addr); end
      checks++; if (dmem_be !== 4'b1111) begin errors++; $display("FAIL wait_be_c%0d: got %b want 1111", i, dmem_be); end
      checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL wait_wb_valid_c%0d: got %b want 0", i, wb_valid); end
      @(negedge clk);
    end
    dmem_ack = 1'b1; dmem_rdata = 32'hDEADBEEF;
    #1;
    checks++; if (ex_ready !== 1'b1) begin errors++; $display("FAIL wait_ready_ack: got %b want 1", ex_ready); end
    @(negedge clk);
    dmem_ack = 1'b0; dmem_rdata = 32'h0; ex_valid = 1'b0;
    checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL wait_wb_valid_done: got %b want 1", wb_valid); end
    checks++; if (wb_load_data !== 32'hDEADBEEF) begin errors++; $display("FAIL wait_load_data: got %h want deadbeef", wb_load_data); end
    checks++; if (wb_rd !== 5'd7) begin errors++; $display("FAIL wait_wb_rd: got %0d want 7", wb_rd); end
    checks++; if (alu_out_forw !== 32'h55) begin errors++; $display("FAIL wait_next_accepted: got %h want 00000055", alu_out_forw); end
    checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL wait_req_after: got %b want 0", dmem_req); end
    @(negedge clk);
    checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL wait_next_wb_valid: got %b want 1", wb_valid); end
    checks++; if (wb_alu_out !== 32'h55) begin errors++; $display("FAIL wait_next_alu: got %h want 00000055", wb_alu_out); end
    checks++; if (wb_rd !== 5'd9) begin errors++; $display("FAIL wait_next_rd: got %0d want 9", wb_rd); end
  endtask

  task automatic test_misalign(input string name, input logic [31:0] addr, input logic [1:0] size);
    @(negedge clk);
    drive_ex(1'b1, addr, 32'h0, 32'h400, 1'b1, 1'b0, size, 1'b0, 5'd3, 1'b1, 2'b10);
    @(negedge clk);
    ex_valid = 1'b0;
    dmem_ack = 1'b1; dmem_rdata = 32'h12345678;
    #1;
    checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL %s_req: got %b want 0", name, dmem_req); end
    checks++; if (ex_ready !== 1'b1) begin errors++; $display("FAIL %s_ready: got %b want 1", name, ex_ready); end
    @(negedge clk);
    dmem_ack = 1'b0; dmem_rdata = 32'h0;
    checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL %s_wb_valid: got %b want 1", name, wb_valid); end
    checks++; if (wb_reg_wen !== 1'b0) begin errors++; $display("FAIL %s_wb_reg_wen: got %b want 0", name, wb_reg_wen); end
    checks++; if (misalign !== 1'b1) begin errors++; $display("FAIL %s_flag: got %b want 1", name, misalign); end
    checks++; if (wb_load_data !== 32'h0) begin errors++; $display("FAIL %s_load_data: got %h want 0", name, wb_load_data); end
    @(negedge clk);
    checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL %s_flag_pulse: got %b want 0", name, misalign); end
  endtask

  task automatic test_reset_in_wait();
    @(negedge clk);
    drive_ex(1'b1, 32'h300, 32'h0, 32'h500, 1'b1, 1'b0, 2'b10, 1'b0, 5'd4, 1'b1, 2'b10);
    @(negedge clk);
    ex_valid = 1'b0;
    checks++; if (ex_ready !== 1'b0) begin errors++; $display("FAIL rstwait_stalled: got %b want 0", ex_ready); end
    rst = 1'b1;
    #1;
    checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL rstwait_req: got %b want 0", dmem_req); end
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL rstwait_wb_valid: got %b want 0", wb_valid); end
    checks++; if (ex_ready !== 1'b1) begin errors++; $display("FAIL rstwait_ready: got %b want 1", ex_ready); end
    @(negedge clk);
    rst = 1'b0;
    dmem_ack = 1'b1; dmem_rdata = 32'hCAFEF00D;
    @(negedge clk);
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL rstwait_no_wb_1: got %b want 0", wb_valid); end
    dmem_ack = 1'b0;
    @(negedge clk);
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL rstwait_no_wb_2: got %b want 0", wb_valid); end
    drive_ex(1'b1, 32'h77, 32'h0, 32'h600, 1'b0, 1'b0, 2'b00, 1'b0, 5'd2, 1'b1, 2'b00);
    @(negedge clk);
    ex_valid = 1'b0;
    @(negedge clk);
    checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL rstwait_new_valid: got %b want 1", wb_valid); end
    checks++; if (wb_alu_out !== 32'h77) begin errors++; $display("FAIL rstwait_new_alu: got %h want 00000077", wb_alu_out); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    drive_ex(1'b1, 32'h400, 32'h0, 32'h700, 1'b1, 1'b0, 2'b10, 1'b0, 5'd10, 1'b1, 2'b10);
    @(negedge clk);
    checks++; if (dmem_addr !== 32'h400) begin errors++; $display("FAIL b2b_addr_a: got %h want 00000400", dmem_addr); end
    dmem_ack = 1'b1; dmem_rdata = 32'h11111111;
    drive_ex(1'b1, 32'h404, 32'h0, 32'h704, 1'b1, 1'b0, 2'b10, 1'b0, 5'd11, 1'b1, 2'b10);
    @(negedge clk);
    ex_valid = 1'b0;
    checks++; if (wb_load_data !== 32'h11111111) begin errors++; $display("FAIL b2b_data_a: got %h want 11111111", wb_load_data); end
    checks++; if (dmem_addr !== 32'h404) begin errors++; $display("FAIL b2b_addr_b: got %h want 00000404", dmem_addr); end
    dmem_rdata = 32'h22222222;
    @(negedge clk);
    dmem_ack = 1'b0;
    checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid_b: got %b want 1", wb_valid); end
    checks++; if (wb_load_data !== 32'h22222222) begin errors++; $display("FAIL b2b_data_b: got %h want 22222222", wb_load_data); end
    checks++; if (wb_rd !== 5'd11) begin errors++; $display("FAIL b2b_rd_b: got %0d want 11", wb_rd); end
  endtask

  task automatic test_stray_ack();
    @(negedge clk);
    dmem_ack = 1'b1; dmem_rdata = 32'hFFFFFFFF;
    #1;
    checks++; if (ex_ready !== 1'b1) begin errors++; $display("FAIL stray_ack_ready: got %b want 1", ex_ready); end
    @(negedge clk);
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL stray_ack_wb: got %b want 0", wb_valid); end
    dmem_ack = 1'b0; dmem_rdata = 32'h0;
  endtask

  initial begin
    rst = 1'b1; dmem_ack = 1'b0; dmem_rdata = 32'h0;
    drive_ex(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 2'b00, 1'b0, 5'd0, 1'b0, 2'b00);
    test_reset();
    test_alu_pass();
    test_load("lb", 32'h103, 2'b00, 1'b0, 32'h80FFFF7F, 32'h100, 4'b1000, 32'hFFFFFF80);
    test_load("lbu", 32'h103, 2'b00, 1'b1, 32'h80FFFF7F, 32'h100, 4'b1000, 32'h00000080);
    test_load("lh", 32'h102, 2'b01, 1'b0, 32'h80017FFF, 32'h100, 4'b1100, 32'hFFFF8001);
    test_load("lhu", 32'h100, 2'b01, 1'b1, 32'h80018765, 32'h100, 4'b0011, 32'h00008765);
    test_load("lw11", 32'h108, 2'b11, 1'b0, 32'hA5A5_1234, 32'h108, 4'b1111, 32'hA5A51234);
    test_store("sh", 32'h102, 2'b01, 32'hAABBCCDD, 4'b1100, 32'hCCDDCCDD);
    test_store("sb", 32'h101, 2'b00, 32'h1234565A, 4'b0010, 32'h5A5A5A5A);
    test_store("sw", 32'h104, 2'b10, 32'h01020304, 4'b1111, 32'h01020304);
    test_wait_states();
    test_misalign("mis_word", 32'h202, 2'b10);
    test_misalign("mis_half", 32'h103, 2'b01);
    test_stray_ack();
    test_reset_in_wait();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
